// File: rtl/comparador_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and result encoding.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result encoding doubles as {gt, lt} of the deciding slice.
  localparam logic [1:0] EQ = 2'b00;
  localparam logic [1:0] LT = 2'b01;
  localparam logic [1:0] GT = 2'b10;

endpackage

// File: rtl/comparador_digito.sv
// Combinational DIGIT-bit unsigned slice comparator.
module comparador_digito #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/comparador_serial.sv
// Serial unsigned comparator: one DIGIT-bit slice per cycle, MSB slice first.
// Optional macro COMPARADOR_EARLY_EXIT_EN ends the comparison right after the first differing slice.
module comparador_serial
  import comparador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_equal_B,
  output logic             A_less_B,
  output logic             A_greater_B
);

  localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("comparador_serial: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t          state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic [1:0]       res;
  logic             decided;
  logic             slice_eq_c;
  logic             slice_lt_c;
  logic             slice_gt_c;
  logic             finish_c;

  comparador_digito #(.DIGIT(DIGIT)) u_digito (
    .a  (sh_a[WIDTH-1 -: DIGIT]),
    .b  (sh_b[WIDTH-1 -: DIGIT]),
    .eq (slice_eq_c),
    .lt (slice_lt_c),
    .gt (slice_gt_c)
  );

  // Leave BUSY once every slice is consumed, or as soon as a slice decided.
  always_comb begin
    finish_c = (cnt == '0);
`ifdef COMPARADOR_EARLY_EXIT_EN
    finish_c = finish_c || decided;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh_a        <= '0;
      sh_b        <= '0;
      cnt         <= '0;
      res         <= EQ;
      decided     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      A_equal_B   <= 1'b0;
      A_less_B    <= 1'b0;
      A_greater_B <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a    <= A;
            sh_b    <= B;
            cnt     <= CW'(N);
            res     <= EQ;
            decided <= 1'b0;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (finish_c) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            A_equal_B   <= (res == EQ);
            A_less_B    <= (res == LT);
            A_greater_B <= (res == GT);
            state       <= DONE;
          end else begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt - CW'(1);
            // Only the first differing slice counts.
            if (!decided && !slice_eq_c) begin
              decided <= 1'b1;
              res     <= {slice_gt_c, slice_lt_c};
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial: 8-bit/2-bit-digit vectors plus a 4-bit/1-bit exhaustive sweep.
`timescale 1ns/1ps
module tb_comparador_serial;

`ifdef COMPARADOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, eq8, lt8, gt8;
  logic       busy4, done4, eq4, lt4, gt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  comparador_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8),
    .A_equal_B(eq8), .A_less_B(lt8), .A_greater_B(gt8)
  );

  comparador_serial #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4),
    .A_equal_B(eq4), .A_less_B(lt4), .A_greater_B(gt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference latency: edges after the accepting edge until done is visible.
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b, input int w, input int d);
    logic [7:0] x;
    int msb;
    x   = a ^ b;
    msb = -1;
    for (int j = 0; j < w; j++) if (x[j]) msb = j;
    if (EARLY && msb >= 0) return (w - 1 - msb) / d + 2;
    return w / d + 1;
  endfunction

  function automatic logic get_done(input bit big);
    return big ? done8 : done4;
  endfunction

  function automatic logic get_busy(input bit big);
    return big ? busy8 : busy4;
  endfunction

  function automatic logic [2:0] get_flags(input bit big);
    return big ? {eq8, lt8, gt8} : {eq4, lt4, gt4};
  endfunction

  task automatic drive(input bit big, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (big) begin
      start8 = st; a8 = a; b8 = b;
    end else begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0];
    end
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic run_cmp(input bit big, input logic [7:0] a, input logic [7:0] b,
                         input bit poke, input string tag);
    int         w, d, lat, cyc, busy_cnt;
    bit         seen;
    logic [2:0] ef;
    w        = big ? 8 : 4;
    d        = big ? 2 : 1;
    lat      = exp_lat(a, b, w, d);
    ef       = {a == b, a < b, a > b};
    busy_cnt = 0;
    seen     = 1'b0;
    drive(big, 1'b1, a, b);
    @(posedge clk); #1;
    drive(big, 1'b0, ~a, ~b);
    for (cyc = 0; cyc < 40; cyc++) begin
      if (get_done(big)) begin
        seen = 1'b1;
        break;
      end
      if (get_busy(big)) busy_cnt++;
      if (poke && cyc == 1) drive(big, 1'b1, b, a);
      else                  drive(big, 1'b0, ~a, ~b);
      @(posedge clk); #1;
    end
    drive(big, 1'b0, ~a, ~b);
    check({tag, " done"},    32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " busycnt"}, 32'(busy_cnt), 32'(lat));
    check({tag, " flags"},   32'(get_flags(big)), 32'(ef));
    if (big) check({tag, " busy@done"}, 32'(get_busy(big)), 32'd0);
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(get_done(big)), 32'd0);
    if (poke) begin
      seen = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (get_done(big)) seen = 1'b1;
      end
      check({tag, " extra done"}, 32'(seen), 32'd0);
    end
  endtask

  initial begin
    bit extra;
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst busy8",  32'(busy8), 32'd0);
    check("rst done8",  32'(done8), 32'd0);
    check("rst flags8", 32'({eq8, lt8, gt8}), 32'd0);
    check("rst flags4", 32'({eq4, lt4, gt4}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmp(1'b1, 8'hA5, 8'hA5, 1'b0, "eq_a5");
    run_cmp(1'b1, 8'h80, 8'h7F, 1'b0, "gt_80_7f");
    run_cmp(1'b1, 8'h00, 8'h01, 1'b0, "lt_00_01");
    run_cmp(1'b1, 8'hFF, 8'h00, 1'b0, "gt_ff_00");
    run_cmp(1'b1, 8'h12, 8'h13, 1'b0, "lt_12_13");
    run_cmp(1'b1, 8'h40, 8'h80, 1'b0, "lt_40_80");
    run_cmp(1'b1, 8'h36, 8'h33, 1'b0, "gt_36_33");
    run_cmp(1'b1, 8'h33, 8'h30, 1'b1, "poke_busy");

    // Abort in the second BUSY cycle; earlier flags are non-zero and must clear.
    drive(1'b1, 1'b1, 8'h12, 8'h34);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'h12, 8'h34);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy",  32'(busy8), 32'd0);
    check("abort done",  32'(done8), 32'd0);
    check("abort flags", 32'({eq8, lt8, gt8}), 32'd0);
    extra = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done8) extra = 1'b1;
    end
    check("abort no done", 32'(extra), 32'd0);

    // rst and start together: reset wins.
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h01, 8'h02);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h01, 8'h02);
    @(posedge clk); #1;
    check("rst+start busy", 32'(busy8), 32'd0);

    run_cmp(1'b1, 8'h5A, 8'h5B, 1'b0, "after_abort");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_cmp(1'b0, 8'(i), 8'(j), 1'b0, $sformatf("w4 %0h/%0h", i, j));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
